glb_bank_alloc: RTL



---
 rtl/glb_pkg.sv | 24 ++
 rtl/glb_bank_run_scan.sv | 62 ++++++
 rtl/glb_bank_alloc.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/glb_pkg.sv
// ---------------------------------------------------------------------------
// glb_pkg
// Shared definitions for the global-buffer bank allocator and its helpers.
//   GLB_NUM_BANK / GLB_NUM_PORT : default bank and port counts
//   alloc_state_e               : allocator FSM states (IDLE, SCAN, RESP)
//   ERR_*                       : response error codes carried on rsp_err
// ---------------------------------------------------------------------------
package glb_pkg;

    localparam int GLB_NUM_BANK = 32;
    localparam int GLB_NUM_PORT = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } alloc_state_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CNT   = 2'd1;
    localparam logic [1:0] ERR_BUSY  = 2'd2;
    localparam logic [1:0] ERR_SPACE = 2'd3;

endpackage

// File: rtl/glb_bank_run_scan.sv
// ---------------------------------------------------------------------------
// glb_bank_run_scan
// Walks the bank-free vector one bank per cycle looking for an ascending run
// of free banks of the requested length. No wrap-around: a run that would
// cross from the last bank back to bank 0 is never formed.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_start       clears the pointer and run length for a new search
//   i_step        evaluate the bank under the pointer this cycle
//   i_bank_free   1 = bank unowned
//   i_num         requested run length
//   o_hit         run of i_num free banks ends at the current pointer
//   o_miss        last bank evaluated without a hit
//   o_first       first bank of the run (valid with o_hit)
// ---------------------------------------------------------------------------
module glb_bank_run_scan #(
    parameter int NUM_BANK = 32,
    parameter int PTR_W    = $clog2(NUM_BANK),
    parameter int NUMB_W   = $clog2(NUM_BANK) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_step,
    input  logic [NUM_BANK-1:0] i_bank_free,
    input  logic [NUMB_W-1:0]   i_num,
    output logic                o_hit,
    output logic                o_miss,
    output logic [PTR_W-1:0]    o_first
);

    logic [PTR_W-1:0]  r_ptr;
    logic [NUMB_W-1:0] r_run;
    logic [NUMB_W-1:0] w_run_next;

    // The run grows on a free bank and collapses on an owned one. A hit is
    // declared on the cycle the grown run reaches the requested length, so
    // the run always ends at the current pointer.
    // The start bank is ptr - num + 1; taking the low PTR_W bits of that
    // difference is the same modular result as computing it at NUMB_W width
    // and truncating afterwards.
    always_comb begin
        w_run_next = i_bank_free[r_ptr] ? (r_run + NUMB_W'(1)) : '0;
        o_hit      = i_step && (w_run_next == i_num);
        o_miss     = i_step && !o_hit && (r_ptr == PTR_W'(NUM_BANK - 1));
        o_first    = r_ptr - i_num[PTR_W-1:0] + PTR_W'(1);
    end

    // Pointer and run advance once per evaluated bank; a new search resets
    // both so the walk always starts from bank 0.
    always_ff @(posedge clk) begin
        if (rst || i_start) begin
            r_ptr <= '0;
            r_run <= '0;
        end else if (i_step) begin
            r_ptr <= r_ptr + PTR_W'(1);
            r_run <= w_run_next;
        end
    end

endmodule

// File: rtl/glb_bank_alloc.sv
// ---------------------------------------------------------------------------
// glb_bank_alloc
// Run-time bank allocator for the global buffer. Owns the port/bank
// ownership matrix (cfg_port_bank_flag, row per port), grants contiguous
// runs of free banks on allocate requests and frees whole rows on release.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   alloc_vld/rdy/port/num     allocate request (port, contiguous bank count)
//   rel_vld/rdy/port           release all banks owned by a port
//   rsp_vld/rdy/ok/err/first   allocate response (err: 0 none, 1 bad count,
//                              2 port busy, 3 no space)
//   cfg_port_bank_flag         ownership matrix, bit p*NUM_BANK+b = port p
//                              owns bank b
//   bank_free                  1 = bank owned by no port
//
// Optional build macro GLB_ALLOC_STAT_EN adds:
//   stat_grant, stat_fail      saturating 16-bit response counters
//   stat_peak_used             highest number of simultaneously owned banks
// ---------------------------------------------------------------------------
module glb_bank_alloc
    import glb_pkg::*;
#(
    parameter int NUM_BANK = GLB_NUM_BANK,
    parameter int NUM_PORT = GLB_NUM_PORT,
    parameter int PORT_W   = $clog2(NUM_PORT),
    parameter int NUMB_W   = $clog2(NUM_BANK) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_vld,
    output logic                         alloc_rdy,
    input  logic [PORT_W-1:0]            alloc_port,
    input  logic [NUMB_W-1:0]            alloc_num,
    input  logic                         rel_vld,
    output logic                         rel_rdy,
    input  logic [PORT_W-1:0]            rel_port,
    output logic                         rsp_vld,
    input  logic                         rsp_rdy,
    output logic                         rsp_ok,
    output logic [1:0]                   rsp_err,
    output logic [$clog2(NUM_BANK)-1:0]  rsp_first,
    output logic [NUM_PORT*NUM_BANK-1:0] cfg_port_bank_flag,
    output logic [NUM_BANK-1:0]          bank_free
`ifdef GLB_ALLOC_STAT_EN
    ,
    output logic [15:0]                  stat_grant,
    output logic [15:0]                  stat_fail,
    output logic [NUMB_W-1:0]            stat_peak_used
`endif
);

    localparam int PTR_W = $clog2(NUM_BANK);

    alloc_state_e                           r_state;
    logic [PORT_W-1:0]                      r_port;
    logic [NUMB_W-1:0]                      r_num;
    logic                                   r_rsp_ok;
    logic [1:0]                             r_rsp_err;
    logic [PTR_W-1:0]                       r_rsp_first;
    logic [NUM_PORT-1:0][NUM_BANK-1:0]      r_matrix;

    logic                w_alloc_fire;
    logic                w_rel_fire;
    logic                w_rsp_fire;
    logic                w_num_bad;
    logic                w_port_busy;
    logic                w_scan_start;
    logic                w_scan_step;
    logic                w_hit;
    logic                w_miss;
    logic [PTR_W-1:0]    w_first;
    logic [NUM_BANK-1:0] w_owned;
    logic [NUM_BANK-1:0] w_grant_mask;

    // Handshakes. Release wins a same-cycle collision by dropping alloc_rdy,
    // so the two can never fire together and the matrix has one writer per
    // cycle.
    always_comb begin
        rel_rdy      = (r_state == IDLE);
        alloc_rdy    = (r_state == IDLE) && !rel_vld;
        rsp_vld      = (r_state == RESP);
        w_alloc_fire = alloc_vld && alloc_rdy;
        w_rel_fire   = rel_vld && rel_rdy;
        w_rsp_fire   = rsp_vld && rsp_rdy;
        rsp_ok       = r_rsp_ok;
        rsp_err      = r_rsp_err;
        rsp_first    = r_rsp_first;
    end

    // Request screening: count check comes before the ownership check, and
    // a port may hold only one run at a time.
    always_comb begin
        w_num_bad   = (alloc_num == '0) || (alloc_num > NUMB_W'(NUM_BANK));
        w_port_busy = 1'b0;
        for (int p = 0; p < NUM_PORT; p++) begin
            if (PORT_W'(p) == alloc_port && (|r_matrix[p])) begin
                w_port_busy = 1'b1;
            end
        end
        w_scan_start = w_alloc_fire && !w_num_bad && !w_port_busy;
        w_scan_step  = (r_state == SCAN);
    end

    // A bank is free when no row claims it.
    always_comb begin
        w_owned = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            w_owned = w_owned | r_matrix[p];
        end
        bank_free          = ~w_owned;
        cfg_port_bank_flag = r_matrix;
    end

    glb_bank_run_scan #(
        .NUM_BANK (NUM_BANK),
        .PTR_W    (PTR_W),
        .NUMB_W   (NUMB_W)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_scan_start),
        .i_step      (w_scan_step),
        .i_bank_free (bank_free),
        .i_num       (r_num),
        .o_hit       (w_hit),
        .o_miss      (w_miss),
        .o_first     (w_first)
    );

    // Banks first .. first+num-1 of a hit. The run ends at or before the
    // last bank, so first+num never exceeds NUM_BANK and fits NUMB_W.
    always_comb begin
        w_grant_mask = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            w_grant_mask[b] = (NUMB_W'(b) >= NUMB_W'(w_first)) &&
                              (NUMB_W'(b) <  NUMB_W'(w_first) + r_num);
        end
    end

    // Control FSM. Rejected requests go straight to RESP; accepted ones scan
    // one bank per cycle and land in RESP with either a grant or no-space.
    // Response fields are only written on the way into RESP, so they hold
    // steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_port      <= '0;
            r_num       <= '0;
            r_rsp_ok    <= 1'b0;
            r_rsp_err   <= ERR_NONE;
            r_rsp_first <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_alloc_fire) begin
                        r_port <= alloc_port;
                        r_num  <= alloc_num;
                        if (w_num_bad) begin
                            r_state     <= RESP;
                            r_rsp_ok    <= 1'b0;
                            r_rsp_err   <= ERR_CNT;
                            r_rsp_first <= '0;
                        end else if (w_port_busy) begin
                            r_state     <= RESP;
                            r_rsp_ok    <= 1'b0;
                            r_rsp_err   <= ERR_BUSY;
                            r_rsp_first <= '0;
                        end else begin
                            r_state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (w_hit) begin
                        r_state     <= RESP;
                        r_rsp_ok    <= 1'b1;
                        r_rsp_err   <= ERR_NONE;
                        r_rsp_first <= w_first;
                    end else if (w_miss) begin
                        r_state     <= RESP;
                        r_rsp_ok    <= 1'b0;
                        r_rsp_err   <= ERR_SPACE;
                        r_rsp_first <= '0;
                    end
                end
                RESP: begin
                    if (w_rsp_fire) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Ownership matrix. The grant is written on the same edge that moves the
    // FSM into RESP, so the new row is visible alongside rsp_vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_matrix <= '0;
        end else begin
            for (int p = 0; p < NUM_PORT; p++) begin
                if (w_rel_fire && PORT_W'(p) == rel_port) begin
                    r_matrix[p] <= '0;
                end else if (w_hit && PORT_W'(p) == r_port) begin
                    r_matrix[p] <= r_matrix[p] | w_grant_mask;
                end
            end
        end
    end

`ifdef GLB_ALLOC_STAT_EN
    logic [15:0]       r_stat_grant;
    logic [15:0]       r_stat_fail;
    logic [NUMB_W-1:0] r_stat_peak;
    logic [NUMB_W-1:0] w_used;

    // Number of banks currently owned by any port.
    always_comb begin
        w_used = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            w_used = w_used + NUMB_W'(w_owned[b]);
        end
    end

    // Outcome counters tick on the response handshake and stick at all-ones;
    // the peak tracks the high-water mark of owned banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_grant <= '0;
            r_stat_fail  <= '0;
            r_stat_peak  <= '0;
        end else begin
            if (w_rsp_fire) begin
                if (r_rsp_ok && r_stat_grant != 16'hFFFF) begin
                    r_stat_grant <= r_stat_grant + 16'd1;
                end else if (!r_rsp_ok && r_stat_fail != 16'hFFFF) begin
                    r_stat_fail <= r_stat_fail + 16'd1;
                end
            end
            if (w_used > r_stat_peak) begin
                r_stat_peak <= w_used;
            end
        end
    end

    assign stat_grant     = r_stat_grant;
    assign stat_fail      = r_stat_fail;
    assign stat_peak_used = r_stat_peak;
`endif

endmodule
